// File: rtl/redmule_cfg_tiler_if.sv
// Handshake and result bundle between the RedMulE slave register file,
// the tiling calculator and the final register-file writer.
interface redmule_cfg_tiler_if;
    logic        clear_i;
    logic        start_i;
    logic        ready_o;
    logic [15:0] m_size_i;
    logic [15:0] n_size_i;
    logic [15:0] k_size_i;
    logic        cfg_valid_o;
    logic        cfg_ready_i;
    logic        err_o;
    logic [15:0] x_rows_iter_o;
    logic [7:0]  x_rows_lftovr_o;
    logic [15:0] x_cols_iter_o;
    logic [7:0]  x_cols_lftovr_o;
    logic [15:0] w_cols_iter_o;
    logic [7:0]  w_cols_lftovr_o;
    logic [15:0] tot_stores_o;
    logic [31:0] x_d1_stride_o;
    logic [31:0] w_d0_stride_o;
    logic [31:0] yz_d0_stride_o;

    modport slave (
        input  clear_i,
        input  start_i,
        output ready_o,
        input  m_size_i,
        input  n_size_i,
        input  k_size_i,
        output cfg_valid_o,
        input  cfg_ready_i,
        output err_o,
        output x_rows_iter_o,
        output x_rows_lftovr_o,
        output x_cols_iter_o,
        output x_cols_lftovr_o,
        output w_cols_iter_o,
        output w_cols_lftovr_o,
        output tot_stores_o,
        output x_d1_stride_o,
        output w_d0_stride_o,
        output yz_d0_stride_o
    );

    modport master (
        output clear_i,
        output start_i,
        input  ready_o,
        output m_size_i,
        output n_size_i,
        output k_size_i,
        input  cfg_valid_o,
        output cfg_ready_i,
        input  err_o,
        input  x_rows_iter_o,
        input  x_rows_lftovr_o,
        input  x_cols_iter_o,
        input  x_cols_lftovr_o,
        input  w_cols_iter_o,
        input  w_cols_lftovr_o,
        input  tot_stores_o,
        input  x_d1_stride_o,
        input  w_d0_stride_o,
        input  yz_d0_stride_o
    );
endinterface

// File: rtl/redmule_cfg_tiler.sv
// Tiling-parameter calculator: turns GEMM sizes M/N/K into iteration
// counts, leftovers, store count and byte strides for the streamers.
module redmule_cfg_tiler #(
    parameter int unsigned ARRAY_WIDTH = 12,
    parameter int unsigned TOT_DEPTH   = 16,
    parameter int unsigned BITW        = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    redmule_cfg_tiler_if.slave cfg
);

    localparam int unsigned TD_LOG  = $clog2(TOT_DEPTH);
    localparam logic [15:0] TD_MASK = 16'(TOT_DEPTH - 1);
    localparam logic [7:0]  DIVISOR = 8'(ARRAY_WIDTH);
    localparam logic [31:0] BYTES   = 32'(BITW / 8);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        CALC,
        DONE
    } state_e;

    typedef struct packed {
        logic [15:0] xri;
        logic [7:0]  xrl;
        logic [15:0] xci;
        logic [7:0]  xcl;
        logic [15:0] wci;
        logic [7:0]  wcl;
        logic [15:0] ts;
        logic [31:0] xs;
        logic [31:0] ws;
    } res_t;

    state_e      state_q;
    logic [15:0] dvd_q;
    logic [7:0]  rem_q;
    logic [4:0]  cnt_q;
    logic [15:0] n_q;
    logic [15:0] k_q;
    logic        ready_q;
    logic        valid_q;
    logic        err_q;
    res_t        res_q;

    logic [8:0]  trial;
    logic        qbit;
    logic [7:0]  rem_d;
    logic [15:0] dvd_d;
    res_t        res_d;
    logic        size_zero;

    // One restoring-division step; the dividend register collects the quotient.
    always_comb begin
        trial = {rem_q, dvd_q[15]};
        qbit  = (trial >= {1'b0, DIVISOR});
        rem_d = qbit ? (trial[7:0] - DIVISOR) : trial[7:0];
        dvd_d = {dvd_q[14:0], qbit};
    end

    // Final tiling values from quotient/remainder and the stored N/K sizes.
    always_comb begin
        res_d     = '0;
        res_d.xri = dvd_q + {15'd0, (rem_q != 8'd0)};
        res_d.xrl = rem_q;
        res_d.xci = (n_q >> TD_LOG) + {15'd0, ((n_q & TD_MASK) != 16'd0)};
        res_d.xcl = 8'(n_q & TD_MASK);
        res_d.wci = (k_q >> TD_LOG) + {15'd0, ((k_q & TD_MASK) != 16'd0)};
        res_d.wcl = 8'(k_q & TD_MASK);
        res_d.ts  = res_d.xri * res_d.wci;
        res_d.xs  = {16'd0, n_q} * BYTES;
        res_d.ws  = {16'd0, k_q} * BYTES;
    end

    assign size_zero = (cfg.m_size_i == 16'd0) ||
                       (cfg.n_size_i == 16'd0) ||
                       (cfg.k_size_i == 16'd0);

    // Control FSM with all result and handshake outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            k_q     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else if (cfg.clear_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cfg.start_i) begin
                        dvd_q   <= cfg.m_size_i;
                        n_q     <= cfg.n_size_i;
                        k_q     <= cfg.k_size_i;
                        rem_q   <= '0;
                        cnt_q   <= 5'd15;
                        ready_q <= 1'b0;
                        if (size_zero) begin
                            err_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= DIV;
                        end
                    end
                end
                DIV: begin
                    dvd_q <= dvd_d;
                    rem_q <= rem_d;
                    if (cnt_q == 5'd0) begin
                        state_q <= CALC;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                CALC: begin
                    res_q   <= res_d;
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    if (cfg.cfg_ready_i) begin
                        res_q   <= '0;
                        err_q   <= 1'b0;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    res_q   <= '0;
                end
            endcase
        end
    end

    assign cfg.ready_o         = ready_q;
    assign cfg.cfg_valid_o     = valid_q;
    assign cfg.err_o           = err_q;
    assign cfg.x_rows_iter_o   = res_q.xri;
    assign cfg.x_rows_lftovr_o = res_q.xrl;
    assign cfg.x_cols_iter_o   = res_q.xci;
    assign cfg.x_cols_lftovr_o = res_q.xcl;
    assign cfg.w_cols_iter_o   = res_q.wci;
    assign cfg.w_cols_lftovr_o = res_q.wcl;
    assign cfg.tot_stores_o    = res_q.ts;
    assign cfg.x_d1_stride_o   = res_q.xs;
    assign cfg.w_d0_stride_o   = res_q.ws;
    assign cfg.yz_d0_stride_o  = res_q.ws;

endmodule

// File: tb/tb_redmule_cfg_tiler.sv
// Bench for redmule_cfg_tiler: vector table with a scoreboard queue,
// plus sequences for held results, ignored start, reset and clear.
module tb_redmule_cfg_tiler;

    typedef struct {
        logic [15:0] m;
        logic [15:0] n;
        logic [15:0] k;
        logic        err;
        logic [15:0] xri;
        logic [7:0]  xrl;
        logic [15:0] xci;
        logic [7:0]  xcl;
        logic [15:0] wci;
        logic [7:0]  wcl;
        logic [15:0] ts;
        logic [31:0] xs;
        logic [31:0] ws;
    } vec_t;

    logic clk;
    logic rst;
    int   nchk;
    int   nerr;
    vec_t tbl [10];
    vec_t sb [$];

    redmule_cfg_tiler_if ifc ();

    redmule_cfg_tiler #(
        .ARRAY_WIDTH(12),
        .TOT_DEPTH  (16),
        .BITW       (16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .cfg  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_all(input vec_t e);
        chk("valid", 32'(ifc.cfg_valid_o), 32'd1);
        chk("err", 32'(ifc.err_o), 32'(e.err));
        chk("x_rows_iter", 32'(ifc.x_rows_iter_o), 32'(e.xri));
        chk("x_rows_lftovr", 32'(ifc.x_rows_lftovr_o), 32'(e.xrl));
        chk("x_cols_iter", 32'(ifc.x_cols_iter_o), 32'(e.xci));
        chk("x_cols_lftovr", 32'(ifc.x_cols_lftovr_o), 32'(e.xcl));
        chk("w_cols_iter", 32'(ifc.w_cols_iter_o), 32'(e.wci));
        chk("w_cols_lftovr", 32'(ifc.w_cols_lftovr_o), 32'(e.wcl));
        chk("tot_stores", 32'(ifc.tot_stores_o), 32'(e.ts));
        chk("x_d1_stride", ifc.x_d1_stride_o, e.xs);
        chk("w_d0_stride", ifc.w_d0_stride_o, e.ws);
        chk("yz_d0_stride", ifc.yz_d0_stride_o, e.ws);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ready"}, 32'(ifc.ready_o), 32'd1);
        chk({nm, "_valid"}, 32'(ifc.cfg_valid_o), 32'd0);
        chk({nm, "_err"}, 32'(ifc.err_o), 32'd0);
        chk({nm, "_xri"}, 32'(ifc.x_rows_iter_o), 32'd0);
        chk({nm, "_ts"}, 32'(ifc.tot_stores_o), 32'd0);
        chk({nm, "_xs"}, ifc.x_d1_stride_o, 32'd0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!ifc.ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_start", 32'(ifc.ready_o), 32'd1);
    endtask

    // mode: 0 normal, 1 ready held high, 2 start poked during DIV,
    // 3 clear in DONE, 4 results held for 5 cycles before accept
    task automatic run_vec(input vec_t v, input int mode);
        int   lat;
        vec_t e;
        wait_ready();
        ifc.m_size_i    = v.m;
        ifc.n_size_i    = v.n;
        ifc.k_size_i    = v.k;
        ifc.start_i     = 1'b1;
        ifc.cfg_ready_i = (mode == 1);
        sb.push_back(v);
        @(posedge clk);
        #1;
        ifc.start_i = 1'b0;
        lat = 0;
        while (!ifc.cfg_valid_o && lat < 40) begin
            if (mode == 2 && lat == 3) begin
                ifc.start_i  = 1'b1;
                ifc.m_size_i = 16'd99;
                ifc.n_size_i = 16'd7;
                ifc.k_size_i = 16'd0;
            end
            if (mode == 2 && lat == 5) ifc.start_i = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        ifc.start_i = 1'b0;
        chk("valid_seen", 32'(ifc.cfg_valid_o), 32'd1);
        e = sb.pop_front();
        if (!ifc.cfg_valid_o) begin
            ifc.cfg_ready_i = 1'b0;
            return;
        end
        chk("latency", 32'(lat + 1), e.err ? 32'd1 : 32'd18);
        cmp_all(e);
        if (mode == 4) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                cmp_all(e);
            end
        end
        if (mode == 3) begin
            @(negedge clk);
            ifc.clear_i = 1'b1;
            @(posedge clk);
            #1;
            ifc.clear_i = 1'b0;
            chk_idle("clear_done");
            return;
        end
        if (mode != 1) begin
            @(negedge clk);
            ifc.cfg_ready_i = 1'b1;
        end
        @(posedge clk);
        #1;
        ifc.cfg_ready_i = 1'b0;
        chk_idle("accept");
    endtask

    task automatic reset_mid_div(input vec_t v);
        int lat;
        wait_ready();
        ifc.m_size_i = v.m;
        ifc.n_size_i = v.n;
        ifc.k_size_i = v.k;
        ifc.start_i  = 1'b1;
        @(posedge clk);
        #1;
        ifc.start_i = 1'b0;
        lat = 0;
        while (lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("div_busy_ready", 32'(ifc.ready_o), 32'd0);
        rst = 1'b1;
        #1;
        chk_idle("rst_div");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        //          m       n       k      err xri   xrl xci   xcl wci   wcl ts     xs       ws
        tbl[0] = '{16'd30, 16'd40, 16'd16, 0, 3, 6, 3, 8, 1, 0, 3, 80, 32};
        tbl[1] = '{16'd24, 16'd16, 16'd32, 0, 2, 0, 1, 0, 2, 0, 4, 32, 64};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 5462, 3, 4096, 15,
                   4096, 15, 24576, 131070, 131070};
        tbl[3] = '{16'd1, 16'd1, 16'd1, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2};
        tbl[4] = '{16'd12, 16'd17, 16'd15, 0, 1, 0, 2, 1, 1, 15, 1, 34, 30};
        tbl[5] = '{16'd255, 16'd256, 16'd100, 0, 22, 3, 16, 0, 7, 4, 154,
                   512, 200};
        tbl[6] = '{16'd0, 16'd5, 16'd5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[7] = '{16'd5, 16'd0, 16'd5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8] = '{16'd5, 16'd5, 16'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[9] = '{16'd13, 16'd1000, 16'd48, 0, 2, 1, 63, 8, 3, 0, 6,
                   2000, 96};

        rst             = 1'b1;
        ifc.clear_i     = 1'b0;
        ifc.start_i     = 1'b0;
        ifc.cfg_ready_i = 1'b0;
        ifc.m_size_i    = '0;
        ifc.n_size_i    = '0;
        ifc.k_size_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(tbl[i], 0);

        run_vec(tbl[3], 1);
        run_vec(tbl[8], 4);
        run_vec(tbl[0], 2);
        reset_mid_div(tbl[2]);
        run_vec(tbl[5], 0);
        run_vec(tbl[9], 3);
        run_vec(tbl[2], 0);
        run_vec(tbl[6], 3);
        run_vec(tbl[4], 0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
